// File: rtl/kbd_event_scheduler.sv
// Merges PS/2 and injector key events into one FIFO and applies them one at a
// time to a 14x7 active-low key matrix, with a hold gap after each change.
module kbd_event_scheduler #(
  parameter int unsigned      FIFO_DEPTH = 8,
  parameter int unsigned      GAP_W      = 20,
  parameter logic [GAP_W-1:0] GAP_CYCLES = 20'd40000
) (
  input  logic                        clk,
  input  logic                        nreset,
  input  logic                        clear,
  input  logic                        ps2_valid,
  input  logic [6:0]                  ps2_code,
  input  logic                        ps2_release,
  input  logic                        inj_valid,
  input  logic [6:0]                  inj_code,
  input  logic                        inj_release,
  output logic                        inj_ready,
  input  logic [13:0]                 cpu_ka,
  output logic [6:0]                  cpu_kd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int unsigned      AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned      CW       = AW + 1;
  localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_CYCLES - GAP_W'(1);

  typedef enum logic [1:0] {IDLE, APPLY, GAP} state_e;

  state_e           state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [6:0]       matrix_q [14];
  logic [6:0]       matrix_d [14];
  logic [6:0]       kd_q, kd_d;

  logic       full, empty, pop, ps2_wr, inj_wr, wr_en;
  logic [7:0] wr_data, head;
  logic [3:0] head_row;
  logic [2:0] head_col;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign pop      = (state_q == APPLY);
  assign head     = mem_q[rd_ptr_q];
  assign head_row = head[6:3];
  assign head_col = head[2:0];

  // A pop in the same cycle frees a slot, so a PS/2 write to a full FIFO still lands.
  assign ps2_wr    = ps2_valid & ~clear & (~full | pop);
  assign inj_ready = ~full & ~ps2_valid & ~clear;
  assign inj_wr    = inj_valid & inj_ready;
  assign wr_en     = ps2_wr | inj_wr;
  assign wr_data   = ps2_valid ? {ps2_release, ps2_code} : {inj_release, inj_code};

  assign cpu_kd     = kd_q;
  assign busy       = ~empty | (state_q != IDLE);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(wr_en) - CW'(pop);
      if (ps2_valid && full && !pop) overflow_d = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    matrix_d = matrix_q;
    if (clear) begin
      state_d  = IDLE;
      gap_d    = '0;
      matrix_d = '{default: 7'h7F};
    end else begin
      case (state_q)
        IDLE: if (!empty) state_d = APPLY;
        APPLY: begin
          // Out-of-range codes are consumed without touching the matrix but still get the gap.
          if (head_row <= 4'd13 && head_col <= 3'd6) matrix_d[head_row][head_col] = head[7];
          gap_d   = GAP_LOAD;
          state_d = GAP;
        end
        GAP: begin
          if (gap_q == '0) state_d = IDLE;
          else             gap_d   = gap_q - GAP_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    kd_d = 7'h7F;
    for (int r = 0; r < 14; r++) begin
      if (!cpu_ka[r]) kd_d = kd_d & matrix_q[r];
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      matrix_q   <= '{default: 7'h7F};
      kd_q       <= 7'h7F;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      matrix_q   <= matrix_d;
      kd_q       <= kd_d;
    end
  end

endmodule
